// File: rtl/arb_requester_if.sv
// Handshake and status bundle between one arbiter client front end and its surroundings.
// The slave modport is the requester's own view; master is the upstream/arbiter side.
interface arb_requester_if #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 8
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          flush;
    logic          arb_req;
    logic          arb_gnt;
    logic          bus_valid;
    logic [W-1:0]  bus_data;
    logic [PW-1:0] count;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_max;
    logic          starve;
    logic          err_spurious;

    modport slave (
        input  in_valid, in_data, flush, arb_gnt,
        output in_ready, arb_req, bus_valid, bus_data, count,
               wait_cnt, wait_max, starve, err_spurious
    );

    modport master (
        output in_valid, in_data, flush, arb_gnt,
        input  in_ready, arb_req, bus_valid, bus_data, count,
               wait_cnt, wait_max, starve, err_spurious
    );
endinterface

// File: rtl/arb_requester.sv
// Client front end for one arbiter port: flit FIFO, request generation, registered
// output beat per grant, grant-wait statistics and a sticky spurious-grant flag.
module arb_requester #(
    parameter int W            = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 16,
    parameter int CW           = 8
) (
    input  logic              clk,
    input  logic              rst,
    arb_requester_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] STARVE_TH = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] WAIT_SAT  = {CW{1'b1}};

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          bus_valid_q, bus_valid_d;
    logic [W-1:0]  bus_data_q, bus_data_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CW-1:0] wait_max_q, wait_max_d;
    logic          err_q, err_d;

    logic empty, full, req, push, pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign req   = !empty && !bus.flush;
    assign push  = bus.in_valid && !full && !bus.flush;
    assign pop   = req && bus.arb_gnt;

    assign bus.in_ready     = !full;
    assign bus.arb_req      = req;
    assign bus.bus_valid    = bus_valid_q;
    assign bus.bus_data     = bus_data_q;
    assign bus.count        = wptr_q - rptr_q;
    assign bus.wait_cnt     = wait_cnt_q;
    assign bus.wait_max     = wait_max_q;
    assign bus.starve       = (wait_cnt_q >= STARVE_TH);
    assign bus.err_spurious = err_q;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        bus_valid_d = pop;
        bus_data_d  = bus_data_q;
        wait_cnt_d  = '0;
        wait_max_d  = wait_max_q;
        err_d       = err_q;

        if (push)
            wptr_d = wptr_q + PW'(1);
        if (bus.flush)
            rptr_d = wptr_q;
        else if (pop)
            rptr_d = rptr_q + PW'(1);

        if (pop)
            bus_data_d = mem_q[rptr_q[AW-1:0]];

        if (req && !bus.arb_gnt)
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + CW'(1);

        if (wait_cnt_q > wait_max_q)
            wait_max_d = wait_cnt_q;

        if (bus.arb_gnt && !req)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            wait_cnt_q  <= '0;
            wait_max_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
            wait_cnt_q  <= wait_cnt_d;
            wait_max_q  <= wait_max_d;
            err_q       <= err_d;
        end
    end

    // Storage needs no reset: pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q[AW-1:0]] <= bus.in_data;
    end
endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: single flit, full/ordering, starvation,
// spurious grant, flush and asynchronous reset scenarios.
module tb_arb_requester;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    arb_requester_if #(.W(32), .DEPTH(4), .CW(8)) ifc ();

    arb_requester #(.W(32), .DEPTH(4), .STARVE_LIMIT(16), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        ifc.flush    = 1'b0;
        ifc.arb_gnt  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic push_flit(input logic [31:0] d);
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        tick();
        ifc.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ifc.count !== 3'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", ifc.count); end
        n_checks++; if (ifc.bus_valid !== 1'b0) begin n_errors++; $display("FAIL reset_bus_valid got %b exp 0", ifc.bus_valid); end
        n_checks++; if (ifc.bus_data !== 32'h0) begin n_errors++; $display("FAIL reset_bus_data got %h exp 0", ifc.bus_data); end
        n_checks++; if (ifc.arb_req !== 1'b0) begin n_errors++; $display("FAIL reset_arb_req got %b exp 0", ifc.arb_req); end
        n_checks++; if (ifc.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b exp 1", ifc.in_ready); end
        n_checks++; if (ifc.starve !== 1'b0) begin n_errors++; $display("FAIL reset_starve got %b exp 0", ifc.starve); end
        n_checks++; if (ifc.wait_cnt !== 8'd0 || ifc.wait_max !== 8'd0) begin n_errors++; $display("FAIL reset_wait got %0d/%0d exp 0/0", ifc.wait_cnt, ifc.wait_max); end
        n_checks++; if (ifc.err_spurious !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b exp 0", ifc.err_spurious); end
    endtask

    task automatic test_single();
        do_reset();
        ifc.in_valid = 1'b1;
        ifc.in_data  = 32'hA5A5_A5A5;
        #1;
        n_checks++; if (ifc.arb_req !== 1'b0) begin n_errors++; $display("FAIL single_req_same_cycle got %b exp 0", ifc.arb_req); end
        tick();
        ifc.in_valid = 1'b0;
        #1;
        n_checks++; if (ifc.arb_req !== 1'b1 || ifc.count !== 3'd1) begin n_errors++; $display("FAIL single_req_next got req=%b cnt=%0d exp 1/1", ifc.arb_req, ifc.count); end
        ifc.arb_gnt = 1'b1;
        tick();
        ifc.arb_gnt = 1'b0;
        #1;
        n_checks++; if (ifc.bus_valid !== 1'b1 || ifc.bus_data !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL single_beat got v=%b d=%h exp 1/a5a5a5a5", ifc.bus_valid, ifc.bus_data); end
        n_checks++; if (ifc.count !== 3'd0 || ifc.arb_req !== 1'b0 || ifc.wait_cnt !== 8'd0) begin n_errors++; $display("FAIL single_after got cnt=%0d req=%b wait=%0d exp 0/0/0", ifc.count, ifc.arb_req, ifc.wait_cnt); end
        tick();
        n_checks++; if (ifc.bus_valid !== 1'b0 || ifc.bus_data !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL single_idle got v=%b d=%h exp 0/a5a5a5a5", ifc.bus_valid, ifc.bus_data); end
    endtask

    task automatic test_full_order();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = 32'(i);
            #1;
            n_checks++; if (ifc.in_ready !== (i <= 4)) begin n_errors++; $display("FAIL full_in_ready_%0d got %b exp %b", i, ifc.in_ready, (i <= 4)); end
            tick();
        end
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.count !== 3'd4 || ifc.in_ready !== 1'b0) begin n_errors++; $display("FAIL full_count got cnt=%0d rdy=%b exp 4/0", ifc.count, ifc.in_ready); end
        n_checks++; if (ifc.wait_cnt !== 8'd4) begin n_errors++; $display("FAIL full_wait got %0d exp 4", ifc.wait_cnt); end
        ifc.arb_gnt = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++; if (ifc.bus_valid !== 1'b1 || ifc.bus_data !== 32'(k)) begin n_errors++; $display("FAIL order_beat_%0d got v=%b d=%h exp 1/%h", k, ifc.bus_valid, ifc.bus_data, 32'(k)); end
        end
        ifc.arb_gnt = 1'b0;
        n_checks++; if (ifc.count !== 3'd0) begin n_errors++; $display("FAIL order_drained got %0d exp 0", ifc.count); end
        push_flit(32'h10);
        push_flit(32'h11);
        ifc.in_valid = 1'b1;
        ifc.in_data  = 32'h12;
        ifc.arb_gnt  = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        n_checks++; if (ifc.count !== 3'd2 || ifc.bus_data !== 32'h10) begin n_errors++; $display("FAIL pushpop got cnt=%0d d=%h exp 2/10", ifc.count, ifc.bus_data); end
        tick();
        n_checks++; if (ifc.bus_data !== 32'h11) begin n_errors++; $display("FAIL pushpop_next got %h exp 11", ifc.bus_data); end
        tick();
        ifc.arb_gnt = 1'b0;
        n_checks++; if (ifc.bus_data !== 32'h12 || ifc.count !== 3'd0) begin n_errors++; $display("FAIL pushpop_last got d=%h cnt=%0d exp 12/0", ifc.bus_data, ifc.count); end
    endtask

    task automatic test_starve();
        do_reset();
        push_flit(32'h5);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 15) begin
                n_checks++; if (ifc.wait_cnt !== 8'd15 || ifc.starve !== 1'b0) begin n_errors++; $display("FAIL starve_15 got w=%0d s=%b exp 15/0", ifc.wait_cnt, ifc.starve); end
            end
            if (c == 16) begin
                n_checks++; if (ifc.wait_cnt !== 8'd16 || ifc.starve !== 1'b1) begin n_errors++; $display("FAIL starve_16 got w=%0d s=%b exp 16/1", ifc.wait_cnt, ifc.starve); end
            end
        end
        n_checks++; if (ifc.wait_cnt !== 8'd20 || ifc.wait_max !== 8'd19) begin n_errors++; $display("FAIL starve_20 got w=%0d m=%0d exp 20/19", ifc.wait_cnt, ifc.wait_max); end
        ifc.arb_gnt = 1'b1;
        #1;
        n_checks++; if (ifc.starve !== 1'b1) begin n_errors++; $display("FAIL starve_gnt_cycle got %b exp 1", ifc.starve); end
        tick();
        ifc.arb_gnt = 1'b0;
        n_checks++; if (ifc.wait_cnt !== 8'd0 || ifc.starve !== 1'b0 || ifc.bus_valid !== 1'b1) begin n_errors++; $display("FAIL starve_clear got w=%0d s=%b v=%b exp 0/0/1", ifc.wait_cnt, ifc.starve, ifc.bus_valid); end
        tick();
        n_checks++; if (ifc.wait_max !== 8'd20) begin n_errors++; $display("FAIL starve_max got %0d exp 20", ifc.wait_max); end
    endtask

    task automatic test_spurious();
        do_reset();
        ifc.arb_gnt = 1'b1;
        tick();
        ifc.arb_gnt = 1'b0;
        n_checks++; if (ifc.err_spurious !== 1'b1 || ifc.bus_valid !== 1'b0) begin n_errors++; $display("FAIL spur_set got e=%b v=%b exp 1/0", ifc.err_spurious, ifc.bus_valid); end
        push_flit(32'h77);
        ifc.arb_gnt = 1'b1;
        tick();
        ifc.arb_gnt = 1'b0;
        n_checks++; if (ifc.err_spurious !== 1'b1 || ifc.bus_data !== 32'h77) begin n_errors++; $display("FAIL spur_sticky got e=%b d=%h exp 1/77", ifc.err_spurious, ifc.bus_data); end
        rst = 1'b0;
        #1;
        n_checks++; if (ifc.err_spurious !== 1'b0) begin n_errors++; $display("FAIL spur_reset got %b exp 0", ifc.err_spurious); end
        rst = 1'b1;
    endtask

    task automatic test_flush();
        do_reset();
        push_flit(32'h31);
        push_flit(32'h32);
        push_flit(32'h33);
        ifc.arb_gnt = 1'b1;
        tick();
        n_checks++; if (ifc.count !== 3'd2 || ifc.bus_data !== 32'h31) begin n_errors++; $display("FAIL flush_pre got cnt=%0d d=%h exp 2/31", ifc.count, ifc.bus_data); end
        ifc.flush    = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 32'h99;
        #1;
        n_checks++; if (ifc.arb_req !== 1'b0) begin n_errors++; $display("FAIL flush_req got %b exp 0", ifc.arb_req); end
        tick();
        ifc.flush    = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.arb_gnt  = 1'b0;
        n_checks++; if (ifc.count !== 3'd0 || ifc.bus_valid !== 1'b0 || ifc.wait_cnt !== 8'd0) begin n_errors++; $display("FAIL flush_after got cnt=%0d v=%b w=%0d exp 0/0/0", ifc.count, ifc.bus_valid, ifc.wait_cnt); end
        n_checks++; if (ifc.bus_data !== 32'h31 || ifc.err_spurious !== 1'b1) begin n_errors++; $display("FAIL flush_data_err got d=%h e=%b exp 31/1", ifc.bus_data, ifc.err_spurious); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push_flit(32'h41);
        push_flit(32'h42);
        push_flit(32'h43);
        push_flit(32'h44);
        ifc.arb_gnt = 1'b1;
        tick();
        ifc.arb_gnt = 1'b0;
        n_checks++; if (ifc.count !== 3'd3 || ifc.bus_valid !== 1'b1) begin n_errors++; $display("FAIL areset_pre got cnt=%0d v=%b exp 3/1", ifc.count, ifc.bus_valid); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (ifc.bus_valid !== 1'b0 || ifc.count !== 3'd0 || ifc.bus_data !== 32'h0) begin n_errors++; $display("FAIL areset_now got v=%b cnt=%0d d=%h exp 0/0/0", ifc.bus_valid, ifc.count, ifc.bus_data); end
        n_checks++; if (ifc.arb_req !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.wait_max !== 8'd0) begin n_errors++; $display("FAIL areset_ctl got req=%b rdy=%b m=%0d exp 0/1/0", ifc.arb_req, ifc.in_ready, ifc.wait_max); end
        #1;
        rst = 1'b1;
        tick();
        n_checks++; if (ifc.count !== 3'd0 || ifc.arb_req !== 1'b0) begin n_errors++; $display("FAIL areset_after got cnt=%0d req=%b exp 0/0", ifc.count, ifc.arb_req); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        test_reset();
        test_single();
        test_full_order();
        test_starve();
        test_spurious();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Client-side front end for one port of the shared round-robin arbiter.
- Buffers incoming flits in a small FIFO and drives one request line to the arbiter while data is pending.
- Each granted cycle pops one flit onto a registered output bus.
- Tracks the wait time for a grant, raises a starvation flag, and flags grants that arrive with no request.

Parameters:
W, 32, flit data width in bits
DEPTH, 4, FIFO entries; power of 2, at least 2
STARVE_LIMIT, 16, wait-cycle threshold for starve; must be less than 2^CW - 1
CW, 8, width of the wait counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0); all state clears immediately
in_valid  input  1  upstream flit valid
in_ready  output  1  FIFO can accept a flit
in_data  input  W  upstream flit payload
flush  input  1  synchronous flush of queued flits
arb_req  output  1  request to the arbiter (one bit of its request vector)
arb_gnt  input  1  grant from the arbiter (same-cycle, combinational from arb_req)
bus_valid  output  1  registered output flit valid
bus_data  output  W  registered output flit payload
count  output  log2(DEPTH)+1  current FIFO occupancy
wait_cnt  output  CW  consecutive cycles arb_req high without arb_gnt, saturating
wait_max  output  CW  largest wait_cnt value seen since reset
starve  output  1  wait_cnt >= STARVE_LIMIT
err_spurious  output  1  sticky: arb_gnt seen while arb_req low

Behaviour:
- Reset values (rst=0): FIFO empty, count=0, bus_valid=0, bus_data=0, wait_cnt=0, wait_max=0, err_spurious=0.
- Reset outputs that follow from state: arb_req=0, in_ready=1, starve=0.
- FIFO pointers: read and write pointers are log2(DEPTH)+1 bits; full and empty come from the MSB compare.
  - Pointer wrap-around follows naturally from the power-of-2 depth.
- in_ready = !full. No bypass: a simultaneous pop does not free a slot in the same cycle.
- Push: in_valid & in_ready & !flush writes in_data at the write pointer.
- arb_req = !empty & !flush. This is combinational from registered state only, never from in_valid.
  - A flit pushed into an empty FIFO therefore requests on the next cycle.
- Pop: arb_req & arb_gnt.
  - The head entry is loaded into bus_data, bus_valid=1 on the next edge, and the read pointer advances.
  - Latency from grant to bus_valid: 1 cycle.
  - Back-to-back grants give back-to-back bus beats.
- bus_valid deasserts on the next edge after a cycle with no pop. bus_data holds its last value when not popping.
- Simultaneous push and pop: count unchanged and both pointers advance.
  - When the FIFO is full, a same-cycle push is refused (in_ready=0).
- flush: at the next edge the read pointer is set to the write pointer (count=0) and bus_valid is cleared to 0.
  - While flush is high: arb_req=0, so no pop is possible, and a push is ignored.
  - Flush also clears wait_cnt; wait_max is kept.
- Wait counter:
  - If arb_req & !arb_gnt: wait_cnt increments, saturating at 2^CW-1.
  - If arb_gnt or !arb_req: wait_cnt goes to 0.
  - wait_max is updated to wait_cnt whenever wait_cnt > wait_max; the comparison uses registered values.
- starve is combinational (wait_cnt >= STARVE_LIMIT) and clears in the cycle after the grant.
- err_spurious: set on any cycle with arb_gnt=1 and arb_req=0, including during flush.
  - No pop occurs on a spurious grant.
  - Cleared only by reset.
- Asynchronous reset mid-operation: any queued flits are lost; bus_valid drops immediately and does not wait for a clock edge.

Test Plan:
1. Single flit: reset, push 0xA5A5A5A5; arb_req=1 the next cycle; drive arb_gnt=1 for one cycle -> bus_valid=1 with bus_data=0xA5A5A5A5 one cycle later, count=0, arb_req=0, wait_cnt=0.
2. Full/ordering: push 5 flits 1..5 with arb_gnt=0 -> in_ready=0 after the 4th, 5th flit refused, count=4; then hold arb_gnt=1 for 4 cycles -> bus_data 1,2,3,4 on consecutive cycles; push and pop in the same cycle at count=2 leaves count=2.
3. Starvation: queue 1 flit, arb_gnt=0 for 20 cycles -> wait_cnt reaches 16 at cycle 16 and starve=1; grant -> wait_cnt=0 and starve=0 next cycle; wait_max holds 20.
4. Spurious grant: empty FIFO, pulse arb_gnt -> err_spurious=1, bus_valid stays 0; err_spurious stays 1 after later normal traffic; clears only on rst=0.
5. Flush mid-stream: 3 flits queued, 1 granted, assert flush with arb_gnt=1 and in_valid=1 -> arb_req=0 that cycle, no pop, no push; count=0 and bus_valid=0 next cycle; wait_cnt=0.
6. Async reset: with count=3 and bus_valid=1, pulse rst low between clock edges -> all outputs reach their reset values immediately without a clock edge; the FIFO is empty after rst returns high.
